bios_boot_watchdog: RTL and testbench
=====================================

Name: bios_boot_watchdog

Overview:
- Boot-sequencing controller for the dual-BIOS socket select.
- Owns the active-BIOS flop that drives the two BIOS chip selects.
- Latches the software-requested next BIOS at each PciReset release and times POST.
- On POST timeout, flips to the other BIOS and pulses a failover reset request to the reset logic in ODS_MR; gives up after both images fail.

Parameters:
- PRESCALE, 33000: Clk cycles per watchdog tick (1 ms at 33 MHz).
- TIMEOUT_TICKS, 2000: ticks allowed from PciReset release to PostDone.
- RST_PULSE_CYC, 16: width of FailoverRst_N low pulse, in Clk cycles.

Ports:
- Clk  input  1  system clock
- Reset_N  input  1  asynchronous active-low reset
- Pwr_ok  input  1  main power good (async, synchronised inside)
- PciReset  input  1  high = platform out of reset (async, synchronised inside)
- PostDone  input  1  BIOS POST-complete strobe/level, active high (async, synchronised inside)
- Next_Bios  input  1  software-selected BIOS for next boot (0/1)
- WdtEn  input  1  watchdog enable; 0 = never fail over
- Active_Bios  output  1  BIOS currently selected
- BIOS_CS_N  output  2  [0] low when Active_Bios=0, [1] low when Active_Bios=1
- FailoverRst_N  output  1  active-low reset request pulse
- BiosFail  output  2  sticky per-BIOS timeout flags
- FailAll  output  1  both BIOS images timed out
- WdtState  output  3  state encoding for debug/status register

Behaviour:
- Reset: Active_Bios=0, BIOS_CS_N=2'b10, FailoverRst_N=1, BiosFail=0, FailAll=0, state OFF, counters 0.
- Synchronisers:
  - Pwr_ok, PciReset and PostDone each pass through a 2-flop synchroniser.
  - All state logic uses the synchronised versions.
  - Input-to-decision latency is 2 Clk.
- BIOS_CS_N is a registered decode of Active_Bios; it changes in the same cycle as Active_Bios.
- States (WdtState): OFF=0, HOLD=1, BOOT=2, DONE=3, FAILOVER=4, DEAD=5.
- OFF:
  - Clears BiosFail and FailAll; Active_Bios holds its value.
  - Pwr_ok=1 -> HOLD.
- HOLD (platform in reset):
  - PciReset rising edge -> Active_Bios<=Next_Bios, BiosFail<=0, clear prescaler and tick counter -> BOOT.
  - The clear of BiosFail applies only when the edge is not the reset issued by FAILOVER (internal retry flag).
  - On a failover retry edge, Active_Bios is left as set by FAILOVER.
- BOOT:
  - Prescaler counts 0..PRESCALE-1 and emits a tick on wrap; the tick counter increments on each tick.
  - PostDone=1 -> DONE.
  - Tick counter reaches TIMEOUT_TICKS with WdtEn=1 -> FAILOVER. Expiry is exactly TIMEOUT_TICKS*PRESCALE Clk after BOOT entry.
  - PostDone and expiry in the same cycle: PostDone wins -> DONE.
  - WdtEn=0: counter saturates at TIMEOUT_TICKS and no failover occurs. If WdtEn later rises while saturated, FAILOVER is taken the next cycle.
  - PciReset falls (warm reset) -> HOLD, counters cleared, no flag set.
- DONE: PciReset falls -> HOLD.
- FAILOVER:
  - Entry cycle: BiosFail[Active_Bios]<=1.
  - If the other BIOS's flag is already 1: FailAll<=1 -> DEAD, no reset pulse.
  - Otherwise: Active_Bios<=~Active_Bios, retry flag set, FailoverRst_N low for exactly RST_PULSE_CYC cycles, then -> HOLD.
- DEAD:
  - Holds Active_Bios, no pulses, FailAll=1.
  - Exits only on Pwr_ok=0 or Reset_N.
- Pwr_ok=0 in any state -> OFF next cycle.
  - An in-progress FailoverRst_N pulse is aborted (driven 1).
  - The retry flag is cleared.
- Widths:
  - Prescaler is clog2(PRESCALE) bits; tick counter is clog2(TIMEOUT_TICKS+1) bits.
  - Reset pulse counter is clog2(RST_PULSE_CYC+1) bits.
  - No wrap-around is permitted in any counter.
- Next_Bios is sampled only on the PciReset release edge; changes at any other time have no effect on Active_Bios.

Test Plan:
Bench uses PRESCALE=4, TIMEOUT_TICKS=10, RST_PULSE_CYC=16 unless noted.
- Normal boot: Pwr_ok=1, Next_Bios=1, release PciReset, PostDone=1 after 20 Clk -> Active_Bios=1, BIOS_CS_N=2'b01, state DONE, FailoverRst_N stays 1, BiosFail=0.
- Timeout failover: Next_Bios=0, release PciReset, no PostDone -> FAILOVER 40 Clk after BOOT entry. Then BiosFail=2'b01, Active_Bios=1, BIOS_CS_N=2'b01, FailoverRst_N low exactly 16 Clk.
- Double failure: repeat the previous case with no PostDone after the retry -> BiosFail=2'b11, FailAll=1, state DEAD, no second reset pulse. Drop Pwr_ok -> OFF, BiosFail=0, FailAll=0.
- Race: assert PostDone so its synchronised value lands on the expiry cycle -> DONE, BiosFail=0, no pulse.
- Warm reset: drop PciReset at tick 7, re-release with Next_Bios=1 -> Active_Bios=1, full 40 Clk window restarts, no flags set.
- Watchdog disabled: WdtEn=0, no PostDone for 200 Clk -> stays BOOT. Raise WdtEn -> FAILOVER next cycle. Also check mid-pulse Pwr_ok drop forces FailoverRst_N=1 within 3 Clk.

Source files
------------

// File: rtl/bios_boot_watchdog.sv
// rtl/bios_boot_watchdog.sv - dual-BIOS boot sequencer with POST watchdog and failover reset request
module bios_boot_watchdog #(
   parameter int PRESCALE      = 33000,
   parameter int TIMEOUT_TICKS = 2000,
   parameter int RST_PULSE_CYC = 16
) (
   input  logic       Clk,
   input  logic       Reset_N,
   input  logic       Pwr_ok,
   input  logic       PciReset,
   input  logic       PostDone,
   input  logic       Next_Bios,
   input  logic       WdtEn,
   output logic       Active_Bios,
   output logic [1:0] BIOS_CS_N,
   output logic       FailoverRst_N,
   output logic [1:0] BiosFail,
   output logic       FailAll,
   output logic [2:0] WdtState
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam int RW = $clog2(RST_PULSE_CYC + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [TW-1:0] TICK_MAX  = TW'(TIMEOUT_TICKS);
   localparam logic [TW-1:0] TICK_LAST = TW'(TIMEOUT_TICKS - 1);
   localparam logic [RW-1:0] PULSE_MAX = RW'(RST_PULSE_CYC);

   typedef enum logic [2:0] {
      OFF      = 3'd0,
      HOLD     = 3'd1,
      BOOT     = 3'd2,
      DONE     = 3'd3,
      FAILOVER = 3'd4,
      DEAD     = 3'd5
   } state_t;

   state_t        state;
   logic [1:0]    pwr_sync;
   logic [1:0]    pci_sync;
   logic [1:0]    post_sync;
   logic          pci_prev;
   logic          pwr_ok_s;
   logic          pci_s;
   logic          post_s;
   logic          pci_rise;
   logic [PW-1:0] presc;
   logic [TW-1:0] ticks;
   logic [RW-1:0] pulse_cnt;
   logic          retry;
   logic          tick;
   logic          expired;

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         pwr_sync  <= '0;
         pci_sync  <= '0;
         post_sync <= '0;
         pci_prev  <= 1'b0;
      end else begin
         pwr_sync  <= {pwr_sync[0], Pwr_ok};
         pci_sync  <= {pci_sync[0], PciReset};
         post_sync <= {post_sync[0], PostDone};
         pci_prev  <= pci_sync[1];
      end
   end

   assign pwr_ok_s = pwr_sync[1];
   assign pci_s    = pci_sync[1];
   assign post_s   = post_sync[1];
   assign pci_rise = pci_s & ~pci_prev;
   assign tick     = (presc == PRESC_MAX);
   // Expiry lands on the edge that produces the final tick, so the window is exactly TIMEOUT_TICKS*PRESCALE.
   assign expired  = (ticks == TICK_MAX) || (tick && (ticks == TICK_LAST));
   assign WdtState = state;

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         state         <= OFF;
         Active_Bios   <= 1'b0;
         BIOS_CS_N     <= 2'b10;
         FailoverRst_N <= 1'b1;
         BiosFail      <= 2'b00;
         FailAll       <= 1'b0;
         presc         <= '0;
         ticks         <= '0;
         pulse_cnt     <= '0;
         retry         <= 1'b0;
      end else if (!pwr_ok_s) begin
         state         <= OFF;
         FailoverRst_N <= 1'b1;
         retry         <= 1'b0;
         presc         <= '0;
         ticks         <= '0;
         pulse_cnt     <= '0;
         if (state == OFF) begin
            BiosFail <= 2'b00;
            FailAll  <= 1'b0;
         end
      end else begin
         case (state)
            OFF: begin
               BiosFail <= 2'b00;
               FailAll  <= 1'b0;
               state    <= HOLD;
            end
            HOLD: begin
               if (pci_rise) begin
                  // A retry boot keeps the image chosen by FAILOVER and its failure history.
                  if (!retry) begin
                     Active_Bios <= Next_Bios;
                     BIOS_CS_N   <= Next_Bios ? 2'b01 : 2'b10;
                     BiosFail    <= 2'b00;
                  end
                  retry <= 1'b0;
                  presc <= '0;
                  ticks <= '0;
                  state <= BOOT;
               end
            end
            BOOT: begin
               if (!pci_s) begin
                  presc <= '0;
                  ticks <= '0;
                  state <= HOLD;
               end else if (post_s) begin
                  state <= DONE;
               end else if (expired && WdtEn) begin
                  presc <= '0;
                  ticks <= '0;
                  state <= FAILOVER;
               end else begin
                  presc <= tick ? '0 : presc + PW'(1);
                  if (tick && (ticks != TICK_MAX)) begin
                     ticks <= ticks + TW'(1);
                  end
               end
            end
            DONE: begin
               if (!pci_s) begin
                  state <= HOLD;
               end
            end
            FAILOVER: begin
               if (pulse_cnt == '0) begin
                  BiosFail[Active_Bios] <= 1'b1;
                  if (BiosFail[~Active_Bios]) begin
                     FailAll <= 1'b1;
                     state   <= DEAD;
                  end else begin
                     Active_Bios   <= ~Active_Bios;
                     BIOS_CS_N     <= Active_Bios ? 2'b10 : 2'b01;
                     retry         <= 1'b1;
                     FailoverRst_N <= 1'b0;
                     pulse_cnt     <= RW'(1);
                  end
               end else if (pulse_cnt == PULSE_MAX) begin
                  FailoverRst_N <= 1'b1;
                  pulse_cnt     <= '0;
                  state         <= HOLD;
               end else begin
                  pulse_cnt <= pulse_cnt + RW'(1);
               end
            end
            DEAD: begin
               state <= DEAD;
            end
            default: begin
               state <= OFF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bios_boot_watchdog.sv
// tb/tb_bios_boot_watchdog.sv - scoreboard bench for bios_boot_watchdog (PRESCALE=4, TIMEOUT_TICKS=10, RST_PULSE_CYC=16)
module tb_bios_boot_watchdog;

   localparam int PRESCALE      = 4;
   localparam int TIMEOUT_TICKS = 10;
   localparam int RST_PULSE_CYC = 16;
   localparam int WINDOW        = PRESCALE * TIMEOUT_TICKS;
   localparam int SYNC_LAT      = 2;

   localparam logic [2:0] S_OFF  = 3'd0;
   localparam logic [2:0] S_HOLD = 3'd1;
   localparam logic [2:0] S_BOOT = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_FO   = 3'd4;
   localparam logic [2:0] S_DEAD = 3'd5;

   logic       Clk;
   logic       Reset_N;
   logic       Pwr_ok;
   logic       PciReset;
   logic       PostDone;
   logic       Next_Bios;
   logic       WdtEn;
   logic       Active_Bios;
   logic [1:0] BIOS_CS_N;
   logic       FailoverRst_N;
   logic [1:0] BiosFail;
   logic       FailAll;
   logic [2:0] WdtState;

   int          n_checks;
   int          n_fail;
   int          rst_low_cnt;
   string       tagq[$];
   int unsigned valq[$];

   bios_boot_watchdog #(
      .PRESCALE     (PRESCALE),
      .TIMEOUT_TICKS(TIMEOUT_TICKS),
      .RST_PULSE_CYC(RST_PULSE_CYC)
   ) dut (
      .Clk          (Clk),
      .Reset_N      (Reset_N),
      .Pwr_ok       (Pwr_ok),
      .PciReset     (PciReset),
      .PostDone     (PostDone),
      .Next_Bios    (Next_Bios),
      .WdtEn        (WdtEn),
      .Active_Bios  (Active_Bios),
      .BIOS_CS_N    (BIOS_CS_N),
      .FailoverRst_N(FailoverRst_N),
      .BiosFail     (BiosFail),
      .FailAll      (FailAll),
      .WdtState     (WdtState)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial rst_low_cnt = 0;
   always @(negedge Clk) begin
      if (FailoverRst_N === 1'b0) rst_low_cnt <= rst_low_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input int unsigned val);
      tagq.push_back(tag);
      valq.push_back(val);
   endtask

   task automatic sb_check(input logic [31:0] obs);
      string       t;
      int unsigned v;
      if (valq.size() == 0) begin
         check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
         t = tagq.pop_front();
         v = valq.pop_front();
         check_eq(t, obs, v);
      end
   endtask

   function automatic int unsigned exp_snap(input logic [2:0] st, input logic fa, input logic [1:0] bf,
                                            input logic rn, input logic act);
      logic [1:0] cs;
      cs = act ? 2'b01 : 2'b10;
      return {22'd0, st, fa, bf, rn, cs, act};
   endfunction

   function automatic logic [31:0] obs_snap();
      return {22'd0, WdtState, FailAll, BiosFail, FailoverRst_N, BIOS_CS_N, Active_Bios};
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic wait_state(input logic [2:0] st, input int limit, output int cnt);
      cnt = 0;
      while (WdtState !== st && cnt < limit) begin
         @(negedge Clk);
         cnt++;
      end
   endtask

   task automatic start_boot(input logic nb);
      int c;
      Next_Bios = nb;
      PciReset  = 1'b1;
      wait_state(S_BOOT, 10, c);
   endtask

   task automatic measure_low(output int w);
      w = 0;
      while (FailoverRst_N === 1'b0 && w < 100) begin
         @(negedge Clk);
         w++;
      end
   endtask

   initial begin
      int c;
      int w;
      int base;
      n_checks  = 0;
      n_fail    = 0;
      Reset_N   = 1'b0;
      Pwr_ok    = 1'b0;
      PciReset  = 1'b0;
      PostDone  = 1'b0;
      Next_Bios = 1'b0;
      WdtEn     = 1'b1;
      cycles(3);
      sb_push("reset_state", exp_snap(S_OFF, 1'b0, 2'b00, 1'b1, 1'b0));
      sb_check(obs_snap());

      Reset_N = 1'b1;
      Pwr_ok  = 1'b1;
      cycles(5);
      sb_push("power_hold", exp_snap(S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0));
      sb_check(obs_snap());

      // Normal boot from BIOS 1
      base = rst_low_cnt;
      start_boot(1'b1);
      sb_push("normal_boot", exp_snap(S_BOOT, 1'b0, 2'b00, 1'b1, 1'b1));
      sb_check(obs_snap());
      cycles(20);
      PostDone = 1'b1;
      cycles(4);
      Next_Bios = 1'b0;
      cycles(2);
      sb_push("normal_done", exp_snap(S_DONE, 1'b0, 2'b00, 1'b1, 1'b1));
      sb_check(obs_snap());
      sb_push("normal_no_pulse", 0);
      sb_check(rst_low_cnt - base);
      PostDone = 1'b0;
      PciReset = 1'b0;
      cycles(5);
      sb_push("normal_back_hold", exp_snap(S_HOLD, 1'b0, 2'b00, 1'b1, 1'b1));
      sb_check(obs_snap());

      // Timeout on BIOS 0, failover to BIOS 1
      start_boot(1'b0);
      wait_state(S_FO, 200, c);
      sb_push("to_failover_cycles", WINDOW);
      sb_check(c);
      sb_push("fo_entry", exp_snap(S_FO, 1'b0, 2'b00, 1'b1, 1'b0));
      sb_check(obs_snap());
      @(negedge Clk);
      sb_push("fo_flip", exp_snap(S_FO, 1'b0, 2'b01, 1'b0, 1'b1));
      sb_check(obs_snap());
      PciReset = 1'b0;
      measure_low(w);
      sb_push("fo_pulse_width", RST_PULSE_CYC);
      sb_check(w);
      start_boot(1'b0);
      sb_push("retry_boot", exp_snap(S_BOOT, 1'b0, 2'b01, 1'b1, 1'b1));
      sb_check(obs_snap());

      // Second image also times out
      wait_state(S_FO, 200, c);
      sb_push("retry_to_failover", WINDOW);
      sb_check(c);
      base = rst_low_cnt;
      @(negedge Clk);
      sb_push("dead_state", exp_snap(S_DEAD, 1'b1, 2'b11, 1'b1, 1'b1));
      sb_check(obs_snap());
      cycles(20);
      sb_push("dead_no_pulse", 0);
      sb_check(rst_low_cnt - base);
      Pwr_ok   = 1'b0;
      PciReset = 1'b0;
      cycles(5);
      sb_push("dead_power_off", exp_snap(S_OFF, 1'b0, 2'b00, 1'b1, 1'b1));
      sb_check(obs_snap());
      Pwr_ok = 1'b1;
      cycles(5);

      // PostDone synchronised onto the expiry cycle
      base = rst_low_cnt;
      start_boot(1'b0);
      cycles(WINDOW - SYNC_LAT - 1);
      PostDone = 1'b1;
      cycles(5);
      sb_push("race_done", exp_snap(S_DONE, 1'b0, 2'b00, 1'b1, 1'b0));
      sb_check(obs_snap());
      sb_push("race_no_pulse", 0);
      sb_check(rst_low_cnt - base);
      PostDone = 1'b0;
      PciReset = 1'b0;
      cycles(5);

      // Warm reset at tick 7 restarts the window
      start_boot(1'b0);
      cycles(7 * PRESCALE);
      PciReset = 1'b0;
      cycles(5);
      sb_push("warm_hold", exp_snap(S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0));
      sb_check(obs_snap());
      start_boot(1'b1);
      sb_push("warm_reboot", exp_snap(S_BOOT, 1'b0, 2'b00, 1'b1, 1'b1));
      sb_check(obs_snap());
      wait_state(S_FO, 200, c);
      sb_push("warm_full_window", WINDOW);
      sb_check(c);
      @(negedge Clk);
      PciReset = 1'b0;
      measure_low(w);
      cycles(2);
      sb_push("warm_fo_hold", exp_snap(S_HOLD, 1'b0, 2'b10, 1'b1, 1'b0));
      sb_check(obs_snap());
      Pwr_ok = 1'b0;
      cycles(5);
      Pwr_ok = 1'b1;
      cycles(5);
      sb_push("power_cycle_clear", exp_snap(S_HOLD, 1'b0, 2'b00, 1'b1, 1'b0));
      sb_check(obs_snap());

      // Watchdog disabled, then enabled while saturated; abort pulse with power loss
      WdtEn = 1'b0;
      start_boot(1'b1);
      cycles(200);
      sb_push("wdt_off_stays_boot", exp_snap(S_BOOT, 1'b0, 2'b00, 1'b1, 1'b1));
      sb_check(obs_snap());
      WdtEn = 1'b1;
      @(negedge Clk);
      sb_push("wdt_on_failover", exp_snap(S_FO, 1'b0, 2'b00, 1'b1, 1'b1));
      sb_check(obs_snap());
      cycles(5);
      sb_push("mid_pulse_low", 0);
      sb_check(FailoverRst_N);
      Pwr_ok = 1'b0;
      c = 0;
      while (FailoverRst_N === 1'b0 && c < 10) begin
         @(negedge Clk);
         c++;
      end
      sb_push("abort_within_3", 1);
      sb_check(c <= 3);
      cycles(5);
      sb_push("abort_off", exp_snap(S_OFF, 1'b0, 2'b00, 1'b1, 1'b0));
      sb_check(obs_snap());

      check_eq("sb_drained", valq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200us;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
